// File: rtl/dyn_array_pkg.sv
// dyn_array_pkg: shared types and default constants for the dynamic array memory.
//   state_e      : controller states (idle / clearing)
//   DefDataW     : default element width in bits
//   DefMaxDepth  : default maximum element count (power of two, >= 2)
package dyn_array_pkg;

  localparam int unsigned DefDataW    = 32;
  localparam int unsigned DefMaxDepth = 16;

  typedef enum logic [0:0] {
    StIdle,
    StClear
  } state_e;

endpackage

// File: rtl/dyn_array_ram.sv
// dyn_array_ram: DATA_W x DEPTH storage, one write port, one synchronous read port.
// Contents have no reset. A read and a write to the same address in the same cycle
// return the old contents (read-first).
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   re_i    : read enable, result appears on rdata_o after the next edge
//   raddr_i : read index
//   rdata_o : registered read data
module dyn_array_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dyn_array_mem.sv
// dyn_array_mem: resizable array of DATA_W elements, up to MAX_DEPTH entries.
// A resize sets the live element count; newly exposed entries are zeroed one per cycle
// while busy is high. Accesses at or beyond the live count are rejected.
//
// Build option: DYN_ARRAY_MEM_PRESERVE_EN
//   undefined : every resize zeroes indices 0..N-1
//   defined   : entries below min(old,new) are kept; only old..new-1 are zeroed on growth
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   resize_valid/ready/size      : resize handshake and requested count (clamped)
//   wr_en/wr_addr/wr_data        : write request; wr_oob pulses when index is out of range
//   rd_en/rd_addr                : read request, one-cycle latency
//   rd_valid/rd_data/rd_oob      : read result; data is 0 when invalid or out of range
//   size                         : current element count
//   busy                         : clear in progress
module dyn_array_mem
  import dyn_array_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_DEPTH = DefMaxDepth,
  localparam int unsigned AW       = $clog2(MAX_DEPTH),
  localparam int unsigned SzW      = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              resize_valid,
  output logic              resize_ready,
  input  logic [SzW-1:0]    resize_size,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_oob,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_oob,
  output logic [SzW-1:0]    size,
  output logic              busy
);

  localparam logic [SzW-1:0] MaxSize = SzW'(MAX_DEPTH);

  state_e         state_q, state_d;
  logic [SzW-1:0] size_q, size_d;
  logic [SzW-1:0] clr_idx_q, clr_idx_d;
  logic [SzW-1:0] clr_end_q, clr_end_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_oob_q, rd_oob_d;
  logic           wr_oob_q, wr_oob_d;

  logic [SzW-1:0]    req_size;
  logic              ram_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign req_size = (resize_size > MaxSize) ? MaxSize : resize_size;

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    clr_idx_d  = clr_idx_q;
    clr_end_d  = clr_end_q;
    rd_valid_d = 1'b0;
    rd_oob_d   = 1'b0;
    wr_oob_d   = 1'b0;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = wr_data;
    ram_re     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Access checks use the size in force this cycle, before any accepted resize.
        if (wr_en) begin
          if ({1'b0, wr_addr} < size_q) begin
            ram_we = 1'b1;
          end else begin
            wr_oob_d = 1'b1;
          end
        end
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_oob_d   = ({1'b0, rd_addr} >= size_q);
          ram_re     = ~rd_oob_d;
        end
        if (resize_valid) begin
          size_d = req_size;
`ifdef DYN_ARRAY_MEM_PRESERVE_EN
          if (req_size > size_q) begin
            clr_idx_d = size_q;
            clr_end_d = req_size;
            state_d   = StClear;
          end
`else
          if (req_size != '0) begin
            clr_idx_d = '0;
            clr_end_d = req_size;
            state_d   = StClear;
          end
`endif
        end
      end
      StClear: begin
        // The write port belongs to the clear sequence; user requests are ignored.
        ram_we    = 1'b1;
        ram_waddr = clr_idx_q[AW-1:0];
        ram_wdata = '0;
        clr_idx_d = clr_idx_q + SzW'(1);
        if (clr_idx_d == clr_end_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      size_q     <= '0;
      clr_idx_q  <= '0;
      clr_end_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_oob_q   <= 1'b0;
      wr_oob_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      clr_idx_q  <= clr_idx_d;
      clr_end_q  <= clr_end_d;
      rd_valid_q <= rd_valid_d;
      rd_oob_q   <= rd_oob_d;
      wr_oob_q   <= wr_oob_d;
    end
  end

  dyn_array_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign resize_ready = (state_q == StIdle);
  assign busy         = (state_q == StClear);
  assign size         = size_q;
  assign wr_oob       = wr_oob_q;
  assign rd_valid     = rd_valid_q;
  assign rd_oob       = rd_oob_q;
  // Gate the RAM output so uninitialised or stale contents never leak out.
  assign rd_data      = (rd_valid_q && !rd_oob_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_dyn_array_mem.sv
// tb_dyn_array_mem: randomized and directed stimulus checked against an array/queue model
// of the resizable memory.
module tb_dyn_array_mem;

  localparam int unsigned DW = 32;
  localparam int unsigned MD = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          resize_valid;
  logic          resize_ready;
  logic [AW:0]   resize_size;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_oob;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_oob;
  logic [AW:0]   size;
  logic          busy;

  dyn_array_mem #(
    .DATA_W    (DW),
    .MAX_DEPTH (MD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .resize_valid (resize_valid),
    .resize_ready (resize_ready),
    .resize_size  (resize_size),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_oob       (wr_oob),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_oob       (rd_oob),
    .size         (size),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: element array, live count, and queue of indices still to be zeroed.
  int unsigned m_mem [MD];
  int unsigned m_size = 0;
  int unsigned m_clr [$];
  logic        e_rd_valid = 1'b0;
  logic        e_rd_oob   = 1'b0;
  logic        e_wr_oob   = 1'b0;
  int unsigned e_rd_data  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int unsigned n;
    if (rst) begin
      m_size = 0;
      m_clr.delete();
      e_rd_valid = 1'b0;
      e_rd_oob   = 1'b0;
      e_rd_data  = 0;
      e_wr_oob   = 1'b0;
    end else if (m_clr.size() != 0) begin
      m_mem[m_clr.pop_front()] = 0;
      e_rd_valid = 1'b0;
      e_rd_oob   = 1'b0;
      e_rd_data  = 0;
      e_wr_oob   = 1'b0;
    end else begin
      e_rd_valid = rd_en;
      e_rd_oob   = rd_en && (int'(rd_addr) >= int'(m_size));
      e_rd_data  = (rd_en && int'(rd_addr) < int'(m_size)) ? m_mem[rd_addr] : 0;
      e_wr_oob   = wr_en && (int'(wr_addr) >= int'(m_size));
      if (wr_en && int'(wr_addr) < int'(m_size)) m_mem[wr_addr] = wr_data;
      if (resize_valid) begin
        n = (int'(resize_size) > int'(MD)) ? MD : int'(resize_size);
`ifdef DYN_ARRAY_MEM_PRESERVE_EN
        for (int i = m_size; i < int'(n); i++) m_clr.push_back(i);
`else
        for (int i = 0; i < int'(n); i++) m_clr.push_back(i);
`endif
        m_size = n;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("size", 64'(size), 64'(m_size));
    check("busy", 64'(busy), 64'(m_clr.size() != 0));
    check("resize_ready", 64'(resize_ready), 64'(m_clr.size() == 0));
    check("rd_valid", 64'(rd_valid), 64'(e_rd_valid));
    check("rd_oob", 64'(rd_oob), 64'(e_rd_oob));
    check("rd_data", 64'(rd_data), 64'(e_rd_data));
    check("wr_oob", 64'(wr_oob), 64'(e_wr_oob));
  endtask

  task automatic quiet();
    resize_valid = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
  endtask

  // Accept a resize and return the number of cycles busy was observed high.
  task automatic do_resize(input int unsigned n, output int unsigned cycles);
    resize_valid = 1'b1;
    resize_size  = n[AW:0];
    tick();
    resize_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic do_wr(input int unsigned a, input int unsigned d);
    wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input int unsigned a);
    rd_en = 1'b1; rd_addr = a[AW-1:0];
    tick();
    rd_en = 1'b0;
  endtask

  int unsigned cyc;

  initial begin
    for (int i = 0; i < int'(MD); i++) m_mem[i] = 0;
    rst = 1'b1; quiet(); resize_size = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Resize 3, fill and read back.
    do_resize(3, cyc);
    check("busy_cycles_3", 64'(cyc), 64'd3);
    for (int i = 0; i < 3; i++) do_wr(i, i + 1);
    for (int i = 0; i < 3; i++) begin
      do_rd(i);
      check("readback", 64'(rd_data), 64'(i + 1));
      check("readback_oob", 64'(rd_oob), 64'd0);
    end

    // Out-of-range read and write.
    do_rd(15);
    check("oob_rd_valid", 64'(rd_valid), 64'd1);
    check("oob_rd_data", 64'(rd_data), 64'd0);
    check("oob_rd_flag", 64'(rd_oob), 64'd1);
    do_wr(5, 32'hdead);
    check("oob_wr_pulse", 64'(wr_oob), 64'd1);
    tick();
    check("oob_wr_drop", 64'(wr_oob), 64'd0);

    // Shrink to 2.
    do_resize(2, cyc);
`ifdef DYN_ARRAY_MEM_PRESERVE_EN
    check("shrink_cycles", 64'(cyc), 64'd0);
    do_rd(0); check("shrink_rd0", 64'(rd_data), 64'd1);
    do_rd(1); check("shrink_rd1", 64'(rd_data), 64'd2);
`else
    check("shrink_cycles", 64'(cyc), 64'd2);
    do_rd(0); check("shrink_rd0", 64'(rd_data), 64'd0);
    do_rd(1); check("shrink_rd1", 64'(rd_data), 64'd0);
`endif

    // Clamp oversize request; preserve mode only clears the grown part.
    do_resize(20, cyc);
    check("clamp_size", 64'(size), 64'd16);
`ifdef DYN_ARRAY_MEM_PRESERVE_EN
    check("clamp_cycles", 64'(cyc), 64'd14);
`else
    check("clamp_cycles", 64'(cyc), 64'd16);
`endif

    // Reset in the middle of a clear.
    do_resize(0, cyc);
    resize_valid = 1'b1; resize_size = 5'd8;
    tick();
    resize_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_size", 64'(size), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(resize_ready), 64'd1);
    do_resize(4, cyc);
    check("post_rst_cycles", 64'(cyc), 64'd4);

    // Read-first on same-cycle read and write.
    do_wr(1, 7);
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 9;
    rd_en = 1'b1; rd_addr = 4'd1;
    tick();
    quiet();
    check("rf_old", 64'(rd_data), 64'd7);
    do_rd(1);
    check("rf_new", 64'(rd_data), 64'd9);

    // Same-cycle resize and write: write uses old size, clear then wipes it.
    resize_valid = 1'b1; resize_size = 5'd6;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h55;
    tick();
    quiet();
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; tick(); end
    do_rd(2);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      rst          = ($urandom_range(0, 299) == 0);
      resize_valid = ($urandom_range(0, 19) == 0);
      resize_size  = 5'($urandom_range(0, 20));
      wr_en        = $urandom_range(0, 1) == 1;
      wr_addr      = 4'($urandom_range(0, 15));
      wr_data      = $urandom;
      rd_en        = $urandom_range(0, 1) == 1;
      rd_addr      = $urandom_range(0, 3) == 0 ? wr_addr : 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0;
    quiet();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dyn_array_mem.md
DYN_ARRAY_MEM -- requirements
Module: dyn_array_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, element width in bits.
REQ-002 The block SHALL have parameter MAX_DEPTH, default 16, maximum element count (power of two, >=2); AW = log2(MAX_DEPTH).
REQ-003 The block SHALL have ports: clk in 1 clock; rst in 1 reset.
REQ-004 The block SHALL have ports: resize_valid in 1 resize request; resize_ready out 1 resize accept; resize_size in AW+1 requested element count.
REQ-005 The block SHALL have ports: wr_en in 1 write strobe; wr_addr in AW index; wr_data in DATA_W data; wr_oob out 1 write-rejected pulse.
REQ-006 The block SHALL have ports: rd_en in 1 read strobe; rd_addr in AW index; rd_valid out 1 read result valid; rd_data out DATA_W data; rd_oob out 1 read out-of-bounds flag.
REQ-007 The block SHALL have ports: size out AW+1 current element count; busy out 1 clear in progress.
REQ-008 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.

Function
REQ-009 The block SHALL have FSM states IDLE and CLEAR; resize_ready = (state==IDLE); busy = (state==CLEAR).
REQ-010 A resize SHALL be accepted on a cycle with resize_valid && resize_ready; size updates on the next edge.
REQ-011 A resize_size > MAX_DEPTH SHALL be clamped to MAX_DEPTH.
REQ-012 Without the macro, an accepted resize SHALL zero indices 0..N-1, one per cycle, in CLEAR; busy stays high for exactly N cycles, then the FSM returns to IDLE.
REQ-013 A resize to 0 SHALL set size to 0 and stay in IDLE with no CLEAR cycles.
REQ-014 In IDLE, a write with wr_addr < size SHALL store wr_data.
REQ-015 A write with wr_addr >= size SHALL be dropped and wr_oob SHALL pulse high for one cycle.
REQ-016 Writes in CLEAR SHALL be dropped silently, with no wr_oob.
REQ-017 Reads SHALL have 1-cycle latency: rd_valid is high the cycle after rd_en; rd_en in CLEAR is ignored.
REQ-018 A read with rd_addr >= size at issue SHALL return rd_data=0 and rd_oob=1, otherwise the stored value and rd_oob=0.
REQ-019 A same-cycle read and write to the same address SHALL return the old data (read-first).
REQ-020 A same-cycle accepted resize and write SHALL apply the write against the old size first; the clear then overwrites it if in range.
REQ-021 rd_data SHALL be 0 whenever rd_valid=0.

Reset
REQ-022 rst SHALL force state IDLE, size=0, busy=0, resize_ready=1, rd_valid=0, rd_data=0, rd_oob=0, wr_oob=0.
REQ-023 rst asserted mid-CLEAR SHALL abort the clear; storage contents are undefined but unreachable because size=0.

Configuration
REQ-024 The macro DYN_ARRAY_MEM_PRESERVE_EN SHALL select resize behaviour.
REQ-025 With DYN_ARRAY_MEM_PRESERVE_EN defined, resize SHALL keep indices below min(old,new) and clear only old..new-1 when growing; shrinking SHALL take 0 CLEAR cycles.
REQ-026 Without DYN_ARRAY_MEM_PRESERVE_EN, resize SHALL clear all new indices as in REQ-012.

Structure
REQ-027 Package dyn_array_pkg SHALL hold the state enum (IDLE, CLEAR) and the default DATA_W/MAX_DEPTH constants.
REQ-028 Storage SHALL be a sub-module dyn_array_ram: single write port, single synchronous read port, DATA_W x MAX_DEPTH, no reset on contents.

Verification
REQ-029 Resize 3, 3 busy cycles; write 1,2,3 to 0..2; read 0..2 -> 1,2,3, rd_oob=0.
REQ-030 size=3, read addr 15 -> rd_valid=1, rd_data=0, rd_oob=1; write addr 5 -> wr_oob pulse, no store.
REQ-031 Contents {1,2,3}, resize 2 -> without macro, reads give 0,0 after 2 busy cycles; with macro, reads give 1,2 and busy never rises.
REQ-032 resize_size=20 with MAX_DEPTH=16 -> size=16; resize_ready low for 16 cycles (no macro).
REQ-033 Assert rst during CLEAR -> next cycle size=0, busy=0, resize_ready=1; the following resize 4 clears normally.
REQ-034 Same-cycle write and read at addr 1 holding 7, writing 9 -> rd_data=7; next read -> 9.
